// File: rtl/spectrum_reader.sv
// Streams one FFT frame out of the window RAM in natural bin order over valid/ready,
// undoing the bit-reversed storage order and tracking the peak bin of the frame.
module spectrum_reader #(
  parameter int SIZE   = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter bit BITREV = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_bin,
  output logic              m_first,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W:0]     rd_bin;
  logic                inflight;
  logic [ADDR_W-1:0]   inflight_bin;
  logic [ADDR_W-1:0]   addr_hold;
  logic [ADDR_W-1:0]   bin_nat;
  logic [ADDR_W-1:0]   bin_rev;
  logic [ADDR_W-1:0]   issue_addr;
  logic [DATA_W-1:0]   fifo_data [2];
  logic [ADDR_W-1:0]   fifo_bin  [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;
  logic [2:0]          occ_after_pop;
  logic                pop;
  logic                issue;
  logic [ADDR_W-1:0]   run_bin;
  logic [DATA_W-1:0]   run_mag;

  assign bin_nat = rd_bin[ADDR_W-1:0];

  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_rev
    assign bin_rev[gi] = bin_nat[ADDR_W-1-gi];
  end

  assign issue_addr = BITREV ? bin_rev : bin_nat;

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_data[rd_ptr];
  assign m_bin   = fifo_bin[rd_ptr];
  assign m_first = m_valid && (m_bin == '0);
  assign m_last  = m_valid && (m_bin == ADDR_W'(SIZE - 1));

  // Reads in flight plus FIFO entries never exceed two, so the FIFO cannot overflow.
  assign occ_after_pop = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == READ) && (rd_bin != (ADDR_W + 1)'(SIZE)) && (occ_after_pop < 3'd2);

  // The address is presented in the issue cycle itself; otherwise the last one is held.
  assign ram_addr = issue ? issue_addr : addr_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_bin <= '0;
      addr_hold    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_bin <= bin_nat;
        addr_hold    <= issue_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_bin[i]  <= '0;
      end
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= ram_dout;
        fifo_bin[wr_ptr]  <= inflight_bin;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_bin   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      peak_bin <= '0;
      peak_mag <= '0;
      run_bin  <= '0;
      run_mag  <= '0;
    end else begin
      done <= 1'b0;
      // Strict compare keeps the lower bin on ties; raw bits order non-negative floats.
      if (pop && (m_data > run_mag)) begin
        run_bin <= m_bin;
        run_mag <= m_data;
      end
      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_bin  <= '0;
            overrun <= 1'b0;
            run_bin <= '0;
            run_mag <= '0;
          end
        end
        READ: begin
          if (issue) begin
            rd_bin <= rd_bin + 1'b1;
          end
          if (rd_bin == (ADDR_W + 1)'(SIZE)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == 2'd0) && !inflight) begin
            state    <= DONE;
            done     <= 1'b1;
            peak_bin <= run_bin;
            peak_mag <= run_mag;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
